// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the MixColumns datapath.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned COL_W       = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return xtime(a);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // Column 0 occupies the top 32 bits of the state.
  function automatic logic [COL_W-1:0] get_col(input logic [AES_STATE_W-1:0] s,
                                               input logic [1:0] idx);
    return s[AES_STATE_W - 1 - COL_W * int'(idx) -: COL_W];
  endfunction

  function automatic logic [AES_STATE_W-1:0] set_col(input logic [AES_STATE_W-1:0] s,
                                                     input logic [1:0] idx,
                                                     input logic [COL_W-1:0] c);
    logic [AES_STATE_W-1:0] r;
    r = s;
    r[AES_STATE_W - 1 - COL_W * int'(idx) -: COL_W] = c;
    return r;
  endfunction

endpackage

// File: rtl/mixcolumn_col.sv
// Combinational MixColumns / InvMixColumns transform of a single 32-bit column.
module mixcolumn_col
  import aes_pkg::*;
#(
  parameter int unsigned INV_EN = 1
) (
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [7:0]  a0, a1, a2, a3;
  logic [31:0] fwd_col;

  assign {a0, a1, a2, a3} = col_in;

  assign fwd_col = {gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
                    a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
                    a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3),
                    gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3)};

  if (INV_EN != 0) begin : g_inv
    logic [31:0] inv_col;
    assign inv_col = {gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3),
                      gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3),
                      gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3),
                      gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3)};
    assign col_out = inv ? inv_col : fwd_col;
  end else begin : g_fwd_only
    // Inverse logic is not built; the mode select has nothing to steer.
    logic unused_inv;
    assign unused_inv = inv;
    assign col_out    = fwd_col;
  end

endmodule

// File: rtl/mixcolumns_serial.sv
// Handshaked MixColumns engine: transforms COLS_PER_CYC columns per beat in place.
module mixcolumns_serial
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYC = 1,
  parameter int unsigned INV_EN       = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(COLS_PER_CYC == 1 || COLS_PER_CYC == 2 || COLS_PER_CYC == 4)) begin : g_bad_cols
    $error("mixcolumns_serial: COLS_PER_CYC must be 1, 2 or 4");
  end

  localparam int unsigned NBEATS = (COLS_PER_CYC == 0) ? 1 : 4 / COLS_PER_CYC;
  // A single-beat build still needs a 1-bit counter to stay legal.
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [AES_STATE_W-1:0] work_q;
  logic [AES_STATE_W-1:0] data_q;
  logic                   mode_q;

  logic [AES_STATE_W-1:0] work_run;
  logic [COL_W-1:0]       col_in  [COLS_PER_CYC];
  logic [COL_W-1:0]       col_out [COLS_PER_CYC];
  logic [1:0]             col_idx [COLS_PER_CYC];
  logic                   take;
  logic                   last_beat;
  logic                   mode_in;

  for (genvar j = 0; j < int'(COLS_PER_CYC); j++) begin : g_col
    assign col_idx[j] = 2'(32'(cnt_q) * COLS_PER_CYC + 32'(j));
    assign col_in[j]  = get_col(work_q, col_idx[j]);

    mixcolumn_col #(
      .INV_EN (INV_EN)
    ) u_col (
      .col_in  (col_in[j]),
      .inv     (mode_q),
      .col_out (col_out[j])
    );
  end

  // Write this beat's transformed columns back into a copy of the work register.
  always_comb begin
    work_run = work_q;
    for (int unsigned j = 0; j < COLS_PER_CYC; j++) begin
      work_run = set_col(work_run, col_idx[j], col_out[j]);
    end
  end

  assign in_ready  = !rst && ((state_q == IDLE) || (state_q == DONE && out_ready));
  assign take      = in_valid && in_ready;
  assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));
  assign mode_in   = (INV_EN != 0) ? in_inv : 1'b0;

  // FSM, beat counter and datapath registers; accept in DONE bypasses IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else if (take) begin
      work_q  <= in_data;
      mode_q  <= mode_in;
      cnt_q   <= '0;
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          work_q <= work_run;
          cnt_q  <= cnt_q + 1'b1;
          if (last_beat) begin
            // Result register only moves here, so it is stable throughout DONE.
            data_q  <= work_run;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mixcolumns_serial.sv
// Directed bench for mixcolumns_serial across column widths and the forward-only build.
module tb_mixcolumns_serial;

  localparam logic [127:0] FIPS_IN   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] VEC_A_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] VEC_A_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] VEC_B_IN  = 128'hd4d4d4d52d26314c01010101c6c6c6c6;
  localparam logic [127:0] VEC_B_OUT = 128'hd5d5d7d64d7ebdf801010101c6c6c6c6;
  localparam logic [127:0] ONES      = 128'h01010101010101010101010101010101;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index 0: 1 col/cyc, 1: 2 col/cyc, 2: 4 col/cyc, 3: 1 col/cyc forward-only.
  logic         in_valid  [4];
  logic         in_ready  [4];
  logic         in_inv    [4];
  logic         out_valid [4];
  logic         out_ready [4];
  logic         busy      [4];
  logic [127:0] in_data   [4];
  logic [127:0] out_data  [4];

  int comps = 0;
  int fails = 0;

  mixcolumns_serial #(.COLS_PER_CYC(1), .INV_EN(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));

  mixcolumns_serial #(.COLS_PER_CYC(2), .INV_EN(1)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));

  mixcolumns_serial #(.COLS_PER_CYC(4), .INV_EN(1)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

  mixcolumns_serial #(.COLS_PER_CYC(1), .INV_EN(0)) u_nf (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3]), .in_inv(in_inv[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .out_data(out_data[3]), .busy(busy[3]));

  // Reference: bitwise shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // Reference forward MixColumns: circulant matrix with first row {2,3,1,1}.
  function automatic logic [127:0] ref_fwd(input logic [127:0] s);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] r;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(coef[(k - row + 4) % 4], s[127 - 32*c - 8*k -: 8]);
        end
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Offer one state at a negedge, report in_ready, and return at the negedge after accept.
  task automatic send(input int i, input logic [127:0] d, input logic inv, output logic rdy);
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_inv[i]   = inv;
    #1;
    rdy = in_ready[i];
    @(posedge clk);
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  // Count rising edges until out_valid, bounded at 20.
  task automatic wait_valid(input int i, output int cyc);
    cyc = 0;
    while (!out_valid[i] && cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic drain(input int i);
    out_ready[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[i] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      comps++;
      if (in_ready[i] !== 1'b0 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0 ||
          out_data[i] !== 128'h0) begin
        fails++;
        $display("FAIL reset_state[%0d]: rdy=%b ov=%b busy=%b data=%h, want 0 0 0 0", i,
                 in_ready[i], out_valid[i], busy[i], out_data[i]);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      comps++;
      if (in_ready[i] !== 1'b1) begin
        fails++;
        $display("FAIL ready_after_reset[%0d]: got %b want 1", i, in_ready[i]);
      end
    end
  endtask

  // Single transactions: unit, data in, inverse flag, expected data, expected latency.
  task automatic test_transforms;
    int           unit [6] = '{0, 0, 0, 1, 2, 2};
    logic         inv  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [127:0] din  [6] = '{FIPS_IN, VEC_A_IN, VEC_B_IN, FIPS_OUT, FIPS_OUT, VEC_A_IN};
    logic [127:0] dexp [6] = '{FIPS_OUT, VEC_A_OUT, VEC_B_OUT, FIPS_IN, FIPS_IN, VEC_A_OUT};
    int           lat  [6] = '{4, 4, 4, 2, 1, 1};
    logic rdy;
    int   cyc;
    for (int n = 0; n < 6; n++) begin
      send(unit[n], din[n], inv[n], rdy);
      comps++;
      if (rdy !== 1'b1) begin
        fails++;
        $display("FAIL xform%0d_in_ready: got %b want 1", n, rdy);
      end
      wait_valid(unit[n], cyc);
      comps++;
      if (cyc !== lat[n]) begin
        fails++;
        $display("FAIL xform%0d_latency: got %0d want %0d", n, cyc, lat[n]);
      end
      comps++;
      if (out_data[unit[n]] !== dexp[n]) begin
        fails++;
        $display("FAIL xform%0d_data: got %h want %h", n, out_data[unit[n]], dexp[n]);
      end
      drain(unit[n]);
      comps++;
      if (out_valid[unit[n]] !== 1'b0 || busy[unit[n]] !== 1'b0) begin
        fails++;
        $display("FAIL xform%0d_idle_after_drain: ov=%b busy=%b want 0 0", n,
                 out_valid[unit[n]], busy[unit[n]]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic rdy;
    int   cyc;
    send(0, FIPS_IN, 1'b0, rdy);
    wait_valid(0, cyc);
    // A waiting producer must not be captured while the result is held.
    in_valid[0] = 1'b1;
    in_data[0]  = VEC_A_IN;
    in_inv[0]   = 1'b0;
    for (int t = 0; t < 10; t++) begin
      #1;
      comps++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== FIPS_OUT || in_ready[0] !== 1'b0) begin
        fails++;
        $display("FAIL hold_cycle%0d: ov=%b data=%h rdy=%b want 1 %h 0", t, out_valid[0],
                 out_data[0], in_ready[0], FIPS_OUT);
      end
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    #1;
    comps++;
    if (in_ready[0] !== 1'b1) begin
      fails++;
      $display("FAIL done_accept_ready: got %b want 1", in_ready[0]);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    comps++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL bypass_to_run: ov=%b busy=%b want 0 1", out_valid[0], busy[0]);
    end
    wait_valid(0, cyc);
    comps++;
    if (cyc !== 4 || out_data[0] !== VEC_A_OUT) begin
      fails++;
      $display("FAIL bypass_result: lat=%0d data=%h want 4 %h", cyc, out_data[0], VEC_A_OUT);
    end
    drain(0);
  endtask

  task automatic test_reset_mid_run;
    logic rdy;
    logic seen;
    int   cyc;
    send(0, VEC_B_IN, 1'b0, rdy);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    comps++;
    if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset_state: busy=%b ov=%b want 0 0", busy[0], out_valid[0]);
    end
    seen = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1) seen = 1'b1;
    end
    comps++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL midrun_no_output: got out_valid=1 want never");
    end
    send(0, FIPS_IN, 1'b0, rdy);
    wait_valid(0, cyc);
    comps++;
    if (cyc !== 4 || out_data[0] !== FIPS_OUT) begin
      fails++;
      $display("FAIL after_reset_txn: lat=%0d data=%h want 4 %h", cyc, out_data[0], FIPS_OUT);
    end
    drain(0);
  endtask

  task automatic test_inv_disabled;
    logic [127:0] din [6];
    logic [127:0] dexp;
    logic         rdy;
    int           cyc;
    din[0] = FIPS_IN;
    din[1] = ONES;
    for (int n = 2; n < 6; n++) din[n] = {$urandom, $urandom, $urandom, $urandom};
    for (int n = 0; n < 6; n++) begin
      dexp = (n == 0) ? FIPS_OUT : (n == 1) ? ONES : ref_fwd(din[n]);
      send(3, din[n], (n < 2) ? 1'b1 : 1'($urandom_range(0, 1)), rdy);
      wait_valid(3, cyc);
      comps++;
      if (out_data[3] !== dexp || cyc !== 4) begin
        fails++;
        $display("FAIL fwd_only%0d: data=%h lat=%0d want %h 4", n, out_data[3], cyc, dexp);
      end
      drain(3);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] vin  [3] = '{FIPS_IN, VEC_A_IN, VEC_B_IN};
    logic [127:0] vexp [3] = '{FIPS_OUT, VEC_A_OUT, VEC_B_OUT};
    int   t_out [3] = '{0, 0, 0};
    int   k_in  = 0;
    int   k_out = 0;
    logic acc;
    out_ready[1] = 1'b1;
    in_inv[1]    = 1'b0;
    in_valid[1]  = 1'b1;
    in_data[1]   = vin[0];
    for (int t = 0; t < 16; t++) begin
      #1;
      acc = in_valid[1] && in_ready[1];
      if (out_valid[1] === 1'b1) begin
        if (k_out < 3) begin
          comps++;
          if (out_data[1] !== vexp[k_out]) begin
            fails++;
            $display("FAIL b2b_data%0d: got %h want %h", k_out, out_data[1], vexp[k_out]);
          end
          t_out[k_out] = t;
        end
        k_out++;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        k_in++;
        if (k_in < 3) in_data[1] = vin[k_in];
        else in_valid[1] = 1'b0;
      end
    end
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b0;
    comps++;
    if (k_out !== 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d results want 3", k_out);
    end
    comps++;
    if (t_out[1] - t_out[0] !== 3 || t_out[2] - t_out[1] !== 3) begin
      fails++;
      $display("FAIL b2b_period: got %0d,%0d want 3,3", t_out[1] - t_out[0],
               t_out[2] - t_out[1]);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid[i]  = 1'b0;
      in_inv[i]    = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b0;
    end
    @(negedge clk);
    test_reset;
    test_transforms;
    test_backpressure;
    test_reset_mid_run;
    test_inv_disabled;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", comps, fails);
    $finish;
  end

endmodule

// File: doc/mixcolumns_serial.md
# mixcolumns_serial

Parametrised AES MixColumns / InvMixColumns engine with valid/ready handshakes on both sides. It processes a 128-bit state in 4/COLS_PER_CYC cycles, handling COLS_PER_CYC columns per cycle. Forward or inverse mode is selected per transaction. It sits between ShiftRows (or InvShiftRows) and AddRoundKey in the round datapath, and replaces the free-running, unhandshaked column multiplier.

## Interface
- COLS_PER_CYC, default 1: columns processed per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- INV_EN, default 1: 1 builds inverse-matrix logic. 0 forces forward mode and ignores in_inv.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input state is offered.
- in_ready  out  1  block can accept a state this cycle.
- in_data  in  128  state; column c = in_data[127-32c -: 32]; row 0 byte is the MSB of each column.
- in_inv  in  1  0 = MixColumns, 1 = InvMixColumns; sampled with in_data.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  128  result, same byte layout as in_data.
- busy  out  1  state is not IDLE.

## Operation
- Internal state:
  - FSM: IDLE, RUN, DONE.
  - 128-bit work register.
  - Column counter, width clog2(NBEATS), where NBEATS = 4/COLS_PER_CYC.
  - mode bit.
- Accept:
  - A transfer occurs on in_valid && in_ready.
  - On accept, load the work register and mode, clear the counter, and go to RUN.
- RUN:
  - Each cycle, columns cnt*COLS_PER_CYC … cnt*COLS_PER_CYC+COLS_PER_CYC-1 are replaced in place with their transformed value.
  - The counter increments each cycle.
  - After the beat where cnt = NBEATS-1, go to DONE.
- Forward mode: b0=2a0^3a1^a2^a3; b1=a0^2a1^3a2^a3; b2=a0^a1^2a2^3a3; b3=3a0^a1^a2^2a3.
- Inverse mode: coefficient rows {0e,0b,0d,09}, {09,0e,0b,0d}, {0d,09,0e,0b}, {0b,0d,09,0e}.
- GF(2^8) arithmetic:
  - xtime(a) = {a[6:0],0} ^ (8'h1b & {8{a[7]}}).
  - Higher coefficients are built from xtime chains and XOR.
  - No carries; all values are 8-bit.
- DONE:
  - out_valid=1 and out_data = work register, held stable until out_ready.
  - On out_ready, if in_valid is also high, the next state is accepted in the same cycle (go to RUN). Otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational and never depends on in_valid.
- in_valid while in RUN is ignored and not captured; the producer must hold it.
- Reset mid-operation: the transaction is discarded. Next cycle state=IDLE, out_valid=0, and nothing further is emitted for it.

## Timing
- Reset values: state IDLE, out_valid 0, busy 0, out_data 128'h0, counter 0, mode 0. in_ready is 1 one cycle after rst deasserts; it is 0 while rst is high.
- Latency: accept at edge k → out_valid high after edge k+NBEATS (COLS_PER_CYC=1: 4 cycles; 2: 2; 4: 1).
- Throughput with out_ready tied high: one state per NBEATS+1 cycles... no DONE-to-RUN bypass is lost. With back-to-back accept in DONE, the rate is one state per NBEATS+1 cycles, since DONE occupies one cycle.
- out_data changes only on the final RUN beat. It never changes while out_valid=1.
- out_ready while not out_valid has no effect.

## Structure
- Package aes_pkg holds:
  - state enum {IDLE, RUN, DONE}.
  - functions xtime, gf_mul2/3/9/b/d/e.
  - column extract/insert helpers.
  - localparam AES_STATE_W=128, COL_W=32.
- Sub-module mixcolumn_col: combinational single-column transform with ports col_in[31:0], inv, col_out[31:0].
  - Instantiated COLS_PER_CYC times.
  - INV_EN passed down so inverse logic is pruned when 0.
- The top holds the FSM, counter, work register and handshakes.

## Test plan
- Forward FIPS-197 vector, COLS_PER_CYC=1: in_data d4bf5d30e0b452aeb84111f11e2798e5, in_inv=0 → out_data 046681e5e0cb199a48f8d37a2806264c; out_valid rises exactly 4 cycles after accept.
- Inverse round trip at COLS_PER_CYC=2 and 4: 046681e5e0cb199a48f8d37a2806264c with in_inv=1 → d4bf5d30e0b452aeb84111f11e2798e5; latency 2 and 1 respectively.
- Column vectors, forward: db135345f20a225c01010101c6c6c6c6 → 8e4da1bc9fdc589d01010101c6c6c6c6. Forward: d4d4d4d52d26314c… → d5d5d7d64d7ebdf8….
- Backpressure: hold out_ready=0 for 10 cycles → out_valid, out_data stable and in_ready=0. Raise out_ready together with in_valid → same-cycle accept of the next state and a correct second result.
- Reset mid-RUN: assert rst on beat 2 of 4 → out_valid never asserts for that state, busy=0 next cycle, and the next transaction is correct.
- INV_EN=0: in_inv=1 with 01010101… input → forward result produced (01010101… unchanged); random forward vectors match the reference model.
